// File: rtl/ifu_align_buffer.sv
// Instruction realignment buffer: stores fetch words as 16-bit parcels and presents
// one whole instruction per cycle (compressed or 32-bit) together with its PC.
module ifu_align_buffer #(
   parameter int               FETCH_W  = 32,
   parameter int               DEPTH    = 8,
   parameter int               XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = 'h8000_0000,
   parameter bit               RVC_EN   = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fetch_valid,
   output logic                fetch_ready,
   input  logic [FETCH_W-1:0]  fetch_data,
   input  logic                flush,
   input  logic [XLEN-1:0]     flush_pc,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [31:0]         instr,
   output logic                instr_compressed,
   output logic                instr_illegal,
   output logic [XLEN-1:0]     instr_pc
);

   localparam int P  = FETCH_W / 16;
   localparam int PW = $clog2(P);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_pc;
   logic [PW-1:0]   r_skip;

   logic [AW-1:0]   w_head_p1;
   logic [15:0]     w_p0;
   logic [15:0]     w_p1;
   logic            w_comp;
   logic            w_valid;
   logic            w_ready;
   logic            w_push;
   logic            w_pop;
   logic [CW-1:0]   w_push_n;
   logic [CW-1:0]   w_pop_n;

   assign w_head_p1 = r_head + AW'(1);
   assign w_p0      = r_mem[r_head];
   assign w_p1      = r_mem[w_head_p1];
   assign w_comp    = (w_p0[1:0] != 2'b11);
   // A 32-bit instruction waits until its upper parcel has arrived.
   assign w_valid   = (r_count != '0) && (w_comp || (r_count >= CW'(2)));
   assign w_ready   = (r_count <= CW'(DEPTH - P));
   assign w_push    = fetch_valid && w_ready && !flush;
   assign w_pop     = w_valid && instr_ready && !flush;
   assign w_push_n  = CW'(P) - CW'(r_skip);
   assign w_pop_n   = w_comp ? CW'(1) : CW'(2);

   // NOTE: parcel storage has no reset; r_count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int i = 0; i < P; i++) begin
            if (i >= int'(r_skip))
               r_mem[r_tail + AW'(i - int'(r_skip))] <= fetch_data[16*i +: 16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_pc    <= RESET_PC;
         r_skip  <= RESET_PC[PW:1];
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_pc    <= {flush_pc[XLEN-1:1], 1'b0};
         r_skip  <= flush_pc[PW:1];
      end else begin
         if (w_push) begin
            r_tail <= r_tail + AW'(w_push_n);
            r_skip <= '0;
         end
         if (w_pop) begin
            r_head <= r_head + AW'(w_pop_n);
            r_pc   <= r_pc + (w_comp ? XLEN'(2) : XLEN'(4));
         end
         r_count <= r_count + (w_push ? w_push_n : '0) - (w_pop ? w_pop_n : '0);
      end
   end

   always_comb begin
      fetch_ready      = w_ready;
      instr_valid      = w_valid;
      instr_pc         = r_pc;
      instr            = '0;
      instr_compressed = 1'b0;
      instr_illegal    = 1'b0;
      if (w_valid) begin
         instr            = w_comp ? {16'h0000, w_p0} : {w_p1, w_p0};
         instr_compressed = w_comp;
         instr_illegal    = w_comp && !RVC_EN;
      end
   end

endmodule

// File: tb/tb_ifu_align_buffer.sv
// Bench for ifu_align_buffer: a 32-bit-fetch instance with RVC enabled and a 64-bit-fetch
// instance with RVC disabled, both checked cycle by cycle against a parcel-queue model.
module tb_ifu_align_buffer;

   logic clk = 1'b0;
   logic reset;

   logic        a_fv, a_fl, a_rdy;
   logic [31:0] a_fd;
   logic [63:0] a_fpc;
   logic        a_frdy, a_v, a_comp, a_ill;
   logic [31:0] a_instr;
   logic [63:0] a_pc;

   logic        b_fv, b_fl, b_rdy;
   logic [63:0] b_fd;
   logic [63:0] b_fpc;
   logic        b_frdy, b_v, b_comp, b_ill;
   logic [31:0] b_instr;
   logic [63:0] b_pc;

   ifu_align_buffer #(.FETCH_W(32), .DEPTH(8), .XLEN(64), .RESET_PC(64'h8000_0000), .RVC_EN(1'b1)) dut_a (
      .clk(clk), .reset(reset),
      .fetch_valid(a_fv), .fetch_ready(a_frdy), .fetch_data(a_fd),
      .flush(a_fl), .flush_pc(a_fpc),
      .instr_valid(a_v), .instr_ready(a_rdy), .instr(a_instr),
      .instr_compressed(a_comp), .instr_illegal(a_ill), .instr_pc(a_pc)
   );

   ifu_align_buffer #(.FETCH_W(64), .DEPTH(8), .XLEN(64), .RESET_PC(64'h8000_0000), .RVC_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset),
      .fetch_valid(b_fv), .fetch_ready(b_frdy), .fetch_data(b_fd),
      .flush(b_fl), .flush_pc(b_fpc),
      .instr_valid(b_v), .instr_ready(b_rdy), .instr(b_instr),
      .instr_compressed(b_comp), .instr_illegal(b_ill), .instr_pc(b_pc)
   );

   always #5 clk = ~clk;

   // Reference model: the live parcels in program order, the PC of the first one,
   // and how many parcels of the next accepted word belong before the target.
   logic [15:0] mq[$];
   logic [63:0] mpc;
   int          mskip;
   int          mp;
   bit          msel;
   bit          mrvc;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      a_fv = 0; a_fl = 0; a_rdy = 0; a_fd = '0; a_fpc = '0;
      b_fv = 0; b_fl = 0; b_rdy = 0; b_fd = '0; b_fpc = '0;
   endtask

   task automatic model_reset(input int p, input bit sel);
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      mpc   = 64'h8000_0000;
      mskip = int'(mpc[3:1]) % p;
      mp    = p;
      msel  = sel;
      mrvc  = (sel == 1'b0);
   endtask

   // One clock: drive the selected instance, compare its outputs with the model, then
   // advance the model by the same inputs.
   task automatic step(input bit fv, input logic [63:0] fd, input bit fl,
                       input logic [63:0] fpc, input bit rdy);
      int          n;
      logic [15:0] p0, p1;
      bit          comp, v, fr;
      logic [31:0] ei;
      logic        ov, oc, oi, ofr;
      logic [31:0] oinstr;
      logic [63:0] opc;
      @(negedge clk);
      idle_inputs();
      if (msel == 1'b0) begin
         a_fv = fv; a_fd = fd[31:0]; a_fl = fl; a_fpc = fpc; a_rdy = rdy;
         ov = a_v; oc = a_comp; oi = a_ill; ofr = a_frdy; oinstr = a_instr; opc = a_pc;
      end else begin
         b_fv = fv; b_fd = fd; b_fl = fl; b_fpc = fpc; b_rdy = rdy;
         ov = b_v; oc = b_comp; oi = b_ill; ofr = b_frdy; oinstr = b_instr; opc = b_pc;
      end
      n    = mq.size();
      p0   = (n >= 1) ? mq[0] : 16'h0000;
      p1   = (n >= 2) ? mq[1] : 16'h0000;
      comp = (n >= 1) && (p0[1:0] != 2'b11);
      v    = comp || (n >= 2);
      ei   = comp ? {16'h0000, p0} : {p1, p0};
      fr   = (n <= 8 - mp);
      check("instr_valid", 64'(ov), 64'(v));
      check("instr_pc", opc, mpc);
      check("fetch_ready", 64'(ofr), 64'(fr));
      check("instr_illegal", 64'(oi), 64'(v && comp && !mrvc));
      if (v) begin
         check("instr", 64'(oinstr), 64'(ei));
         check("instr_compressed", 64'(oc), 64'(comp));
      end
      @(posedge clk);
      if (fl) begin
         mq.delete();
         mpc   = {fpc[63:1], 1'b0};
         mskip = int'(fpc[3:1]) % mp;
      end else begin
         if (v && rdy) begin
            mq.pop_front();
            if (!comp) mq.pop_front();
            mpc = mpc + (comp ? 64'd2 : 64'd4);
         end
         if (fv && fr) begin
            for (int i = mskip; i < mp; i++) mq.push_back(fd[16*i +: 16]);
            mskip = 0;
         end
      end
   endtask

   task automatic random_run(input int cycles, input int ready_pct, input int flush_pct);
      for (int c = 0; c < cycles; c++) begin
         step($urandom_range(0, 99) < 85, {$urandom, $urandom},
              $urandom_range(0, 99) < flush_pct, {32'h0, $urandom},
              $urandom_range(0, 99) < ready_pct);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();

      // 32-bit fetch, RVC enabled: reset state
      model_reset(2, 1'b0);
      check("reset_instr", 64'(a_instr), 64'h0);
      check("reset_compressed", 64'(a_comp), 64'h0);
      check("reset_valid", 64'(a_v), 64'h0);
      check("reset_pc", a_pc, 64'h8000_0000);
      check("reset_fetch_ready", 64'(a_frdy), 64'h1);

      // Two compressed parcels from one word
      step(1, 64'h0041_4501, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      // 32-bit instruction straddling two fetch words
      step(0, 0, 1, 64'h0, 0);
      step(1, 64'h0513_4505, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(1, 64'h4501_0000, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      // Redirect to a halfword target with a fetch presented in the flush cycle
      step(1, 64'h1234_5679, 1, 64'h8000_0102, 0);
      step(0, 0, 0, 0, 0);
      step(1, 64'h4585_ffff, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      // Backpressure: fill to capacity with 32-bit instructions, then one pop
      step(0, 0, 1, 64'h0, 0);
      for (int i = 0; i < 5; i++) step(1, {32'h0, 16'(i + 1), 16'h0013}, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 64'h0000_0077_0000_0093, 0, 0, 1);
      step(1, 64'h0000_0000_0000_00a3, 0, 0, 0);
      step(1, 64'h0000_0000_0000_00b3, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

      // Sustained push and pop across many pointer wraps, then mixed traffic
      step(0, 0, 1, 64'h0000_0000_0000_1000, 0);
      random_run(150, 100, 0);
      random_run(250, 60, 3);

      // 64-bit fetch, RVC disabled: redirect, illegal compressed, legal 32-bit
      model_reset(4, 1'b1);
      check("b_reset_pc", b_pc, 64'h8000_0000);
      check("b_reset_valid", 64'(b_v), 64'h0);
      step(1, 64'hdead_beef_cafe_f00d, 1, 64'h8000_0102, 0);
      step(0, 0, 0, 0, 0);
      step(1, 64'h0000_0513_4501_ffff, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      random_run(200, 70, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
